// File: rtl/vecmat_mac_stream.sv
// Streaming 1xVEC_LEN by VEC_LEN x NUM_COLS vector-matrix MAC, one saturated column per handshake.
// Optional per-column bias input enabled by defining VECMAT_MAC_BIAS_EN.
module vecmat_mac_stream #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_SZ      = 10,
    parameter int ACC_WIDTH    = 40,
    parameter int OUT_WIDTH    = 32,
    parameter int VEC_LEN      = 6,
    parameter int NUM_COLS     = 100,
    parameter int A_ADDR_WIDTH = 3,
    parameter int B_ADDR_WIDTH = 10,
    parameter int COL_WIDTH    = 7,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a_element,
    input  logic [DATA_WIDTH-1:0]   b_element,
    output logic                    rd_en,
    output logic [A_ADDR_WIDTH-1:0] a_addr,
    output logic [B_ADDR_WIDTH-1:0] b_addr,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_sat,
    output logic [COL_WIDTH-1:0]    out_col,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef VECMAT_MAC_BIAS_EN
    input  logic [DATA_WIDTH-1:0]   bias_element,
    output logic [COL_WIDTH-1:0]    bias_addr,
`endif
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUTPUT, DONE} state_t;

    localparam logic [A_ADDR_WIDTH-1:0] LAST_K   = A_ADDR_WIDTH'(VEC_LEN - 1);
    localparam logic [COL_WIDTH-1:0]    LAST_COL = COL_WIDTH'(NUM_COLS - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    logic [A_ADDR_WIDTH-1:0]        k;
    logic [COL_WIDTH-1:0]           col;
    logic [MEM_LATENCY-1:0]         rd_vld_p0;
    logic                           vld_p1;
    logic signed [2*DATA_WIDTH-1:0] prod_p1;
    logic signed [DATA_WIDTH-1:0]   bias_p1;
    logic signed [ACC_WIDTH-1:0]    acc_p2;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    bias_ext;
    logic signed [DATA_WIDTH-1:0]   a_s;
    logic signed [DATA_WIDTH-1:0]   b_s;
    logic                           pipe_empty;
    logic                           accept;

    // Returns {sat_flag, clamped_value}.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > OUT_MAX)
            return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        else if (v < OUT_MIN)
            return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        else
            return {1'b0, v[OUT_WIDTH-1:0]};
    endfunction

    assign a_s        = $signed(a_element);
    assign b_s        = $signed(b_element);
    assign prod_ext   = ACC_WIDTH'(prod_p1);
    assign bias_ext   = ACC_WIDTH'(bias_p1) <<< FRAC_SZ;
    assign pipe_empty = (rd_vld_p0 == '0) && !vld_p1;
    assign accept     = (state == OUTPUT) && out_valid && out_ready;
    assign a_addr     = k;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:   if (start) state_nxt = ISSUE;
            ISSUE: begin
                rd_en = 1'b1;
                if (k == LAST_K) state_nxt = DRAIN;
            end
            DRAIN:  if (pipe_empty) state_nxt = OUTPUT;
            OUTPUT: if (out_ready) state_nxt = (col == LAST_COL) ? DONE : ISSUE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // b_addr runs continuously across columns, so it already holds the next base after a column.
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            col       <= '0;
            b_addr    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_col   <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    k      <= '0;
                    col    <= '0;
                    b_addr <= '0;
                end
                ISSUE: begin
                    b_addr <= b_addr + B_ADDR_WIDTH'(1);
                    k      <= (k == LAST_K) ? '0 : k + A_ADDR_WIDTH'(1);
                end
                DRAIN: if (pipe_empty) begin
                    {out_sat, out_data} <= saturate(acc_p2);
                    out_col             <= col;
                    out_valid           <= 1'b1;
                end
                OUTPUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    k         <= '0;
                    if (col != LAST_COL) col <= col + COL_WIDTH'(1);
                end
                DONE: begin
                    k      <= '0;
                    col    <= '0;
                    b_addr <= '0;
                end
                default: ;
            endcase
        end
    end

    // p0: read-valid delay line matching the memory latency
    always_ff @(posedge clk) begin
        if (rst)
            rd_vld_p0 <= '0;
        else
            rd_vld_p0 <= (rd_vld_p0 << 1) | MEM_LATENCY'(rd_en);
    end

    // p1: product of the returned operands
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            prod_p1 <= '0;
        end else begin
            vld_p1 <= rd_vld_p0[MEM_LATENCY-1];
            if (rd_vld_p0[MEM_LATENCY-1])
                prod_p1 <= (2*DATA_WIDTH)'(a_s) * (2*DATA_WIDTH)'(b_s);
        end
    end

`ifdef VECMAT_MAC_BIAS_EN
    logic [MEM_LATENCY-1:0] first_p0;

    assign bias_addr = col;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_p0 <= '0;
            bias_p1  <= '0;
        end else begin
            first_p0 <= (first_p0 << 1) | MEM_LATENCY'(rd_en && (k == '0));
            if (rd_vld_p0[MEM_LATENCY-1])
                bias_p1 <= first_p0[MEM_LATENCY-1] ? $signed(bias_element) : '0;
        end
    end
`else
    assign bias_p1 = '0;
`endif

    // p2: wide accumulation, cleared when the column result is taken
    always_ff @(posedge clk) begin
        if (rst)
            acc_p2 <= '0;
        else if (accept)
            acc_p2 <= '0;
        else if (vld_p1)
            acc_p2 <= acc_p2 + prod_ext + bias_ext;
    end

endmodule
